// File: rtl/ball_handoff_ctrl.sv
// ball_handoff_ctrl: two-board ball ownership sequencer.
// Packs the ball for I2C transmit with bounded retry and unpacks returned balls.
`default_nettype none

module ball_handoff_ctrl #(
    parameter int TIMEOUT_CYC = 2500000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y_in,
    input  logic [7:0] ball_vy_in,
    input  logic [1:0] gravity_in,
    input  logic [7:0] speed_in,
    output logic       i2c_start,
    output logic [7:0] tx_y0,
    output logic [7:0] tx_y1,
    output logic [7:0] tx_yspeed,
    output logic [7:0] tx_gravity,
    output logic [7:0] tx_speed,
    input  logic       is_i2c_master_done,
    input  logic       i2c_nack,
    input  logic       go_left,
    input  logic [7:0] slv_reg0_y0,
    input  logic [7:0] slv_reg1_y1,
    input  logic [7:0] slv_reg2_Yspeed,
    input  logic [7:0] slv_reg3_gravity,
    input  logic [7:0] slv_reg4_ballspeed,
    output logic       ball_load,
    output logic [9:0] load_y,
    output logic [7:0] load_vy,
    output logic [1:0] load_gravity,
    output logic [7:0] load_speed,
    output logic       local_active,
    output logic       responsing_i2c,
    output logic       link_error,
    output logic [7:0] contrl_led
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLAY_LOCAL  = 3'd1,
        SEND        = 3'd2,
        WAIT_DONE   = 3'd3,
        PLAY_REMOTE = 3'd4,
        LOAD        = 3'd5,
        ERROR       = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pending_q, pending_d;
    logic          latch_tx;

    logic [7:0] tx_y0_q, tx_y1_q, tx_yspeed_q, tx_gravity_q, tx_speed_q;
    logic [9:0] load_y_q;
    logic [7:0] load_vy_q, load_speed_q;
    logic [1:0] load_gravity_q;
    logic       i2c_start_q, ball_load_q, local_active_q, resp_q, link_error_q;
    logic [7:0] led_q;

    logic [9:0] w_raw_y;
    logic       w_clamp_y;
    logic       w_unused;

    assign w_raw_y   = {slv_reg0_y0[1:0], slv_reg1_y1};
    assign w_clamp_y = (slv_reg0_y0[7:2] != 6'd0) || (w_raw_y > 10'd479);
    assign w_unused  = ^slv_reg3_gravity[7:2];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        pending_d = pending_q;
        latch_tx  = 1'b0;
        case (state_q)
            IDLE: begin
                if (game_start)   state_d = PLAY_LOCAL;
                else if (go_left) state_d = LOAD;
            end
            PLAY_LOCAL: begin
                if (ball_send_trigger) begin
                    state_d  = SEND;
                    latch_tx = 1'b1;
                    retry_d  = '0;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT_DONE;
                if (go_left) pending_d = 1'b1;
            end
            WAIT_DONE: begin
                if (go_left) pending_d = 1'b1;
                // Saturating increment: the timer leaves this state at TMAX anyway.
                if (timer_q != TMAX) timer_d = timer_q + TW'(1);
                if (is_i2c_master_done && !i2c_nack) begin
                    state_d = PLAY_REMOTE;
                end else if (is_i2c_master_done || (timer_q == TMAX)) begin
                    if (retry_q < RMAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SEND;
                    end else begin
                        state_d   = ERROR;
                        pending_d = 1'b0;
                    end
                end
            end
            PLAY_REMOTE: begin
                if (go_left || pending_q) begin
                    state_d   = LOAD;
                    pending_d = 1'b0;
                end
            end
            LOAD:  state_d = PLAY_LOCAL;
            ERROR: if (game_start) state_d = PLAY_LOCAL;
            default: state_d = IDLE;
        endcase
        if (game_over && (state_q != IDLE) && (state_q != ERROR)) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            latch_tx  = 1'b0;
        end
    end

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            retry_q        <= '0;
            pending_q      <= 1'b0;
            tx_y0_q        <= '0;
            tx_y1_q        <= '0;
            tx_yspeed_q    <= '0;
            tx_gravity_q   <= '0;
            tx_speed_q     <= '0;
            load_y_q       <= '0;
            load_vy_q      <= '0;
            load_gravity_q <= '0;
            load_speed_q   <= '0;
            i2c_start_q    <= 1'b0;
            ball_load_q    <= 1'b0;
            local_active_q <= 1'b0;
            resp_q         <= 1'b0;
            link_error_q   <= 1'b0;
            led_q          <= 8'h01;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pending_q <= pending_d;
            if (latch_tx) begin
                tx_y0_q      <= {6'b0, ball_y_in[9:8]};
                tx_y1_q      <= ball_y_in[7:0];
                tx_yspeed_q  <= ball_vy_in;
                tx_gravity_q <= {6'b0, gravity_in};
                tx_speed_q   <= speed_in;
            end
            if (state_d == LOAD) begin
                load_y_q       <= w_clamp_y ? 10'd479 : w_raw_y;
                load_vy_q      <= slv_reg2_Yspeed;
                load_gravity_q <= slv_reg3_gravity[1:0];
                load_speed_q   <= (slv_reg4_ballspeed == 8'd0) ? 8'd1 : slv_reg4_ballspeed;
            end
            // Status outputs track the next state so every output is registered.
            i2c_start_q    <= (state_d == SEND);
            ball_load_q    <= (state_d == LOAD);
            local_active_q <= (state_d == PLAY_LOCAL);
            resp_q         <= (state_d == SEND) || (state_d == WAIT_DONE);
            link_error_q   <= (state_d == ERROR);
            led_q          <= 8'h01 << state_d;
        end
    end

    assign i2c_start      = i2c_start_q;
    assign tx_y0          = tx_y0_q;
    assign tx_y1          = tx_y1_q;
    assign tx_yspeed      = tx_yspeed_q;
    assign tx_gravity     = tx_gravity_q;
    assign tx_speed       = tx_speed_q;
    assign ball_load      = ball_load_q;
    assign load_y         = load_y_q;
    assign load_vy        = load_vy_q;
    assign load_gravity   = load_gravity_q;
    assign load_speed     = load_speed_q;
    assign local_active   = local_active_q;
    assign responsing_i2c = resp_q;
    assign link_error     = link_error_q;
    assign contrl_led     = led_q;

endmodule

`default_nettype wire
